uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, character width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  host write strobe, one character per cycle.
REQ-006 wr_data  input  DATA_W  host character.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 empty  output  1  FIFO holds zero entries.
REQ-009 level  output  clog2(DEPTH)+1  current entry count.
REQ-010 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-012 tx_data  output  DATA_W  character presented with tx_start; held stable until the next launch.
REQ-013 tx_busy  input  1  transmitter busy, from the UART transmitter.

Function
REQ-014 A write with wr_en=1 and full=0 SHALL store wr_data at the tail; level increments on the next edge.
REQ-015 A write with full=1 SHALL be dropped and SHALL pulse overflow for one cycle, even if a pop occurs in the same cycle.
REQ-016 Simultaneous accepted write and pop SHALL leave level unchanged.
REQ-017 Read and write pointers SHALL be clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty on wrap.
REQ-018 Launch FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE to LAUNCH when empty=0 and tx_busy=0; on this edge the head SHALL be popped into the tx_data register.
REQ-020 LAUNCH SHALL drive tx_start=1 for exactly that one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY goes to WAIT_DONE when tx_busy=1.
REQ-022 WAIT_BUSY SHALL return to IDLE after 4 cycles with tx_busy=0, which covers a transmitter that finished or ignored the launch. The character is not retried.
REQ-023 WAIT_DONE goes to IDLE when tx_busy=0.
REQ-024 Latency: in IDLE with the FIFO empty, a write at edge N SHALL give tx_start=1 in the cycle after edge N+2.
REQ-025 At most one launch per character; tx_start SHALL never be asserted on two consecutive cycles.
REQ-026 Characters SHALL be launched in write order, with no loss except overflow drops.

Reset
REQ-027 While rst_n=0: pointers=0, level=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, state=IDLE.
REQ-028 Reset asserted mid-operation SHALL discard all queued characters and abort any wait state; FIFO storage contents need not be cleared.
REQ-029 After reset deassertion, no tx_start before the first accepted write.

Structure
REQ-030 A shared uart_pkg SHALL hold the FSM state encoding, the WAIT_BUSY timeout constant (4), and the default DATA_W.
REQ-031 Storage and pointers SHALL be one sub-module, sync_fifo (parameters DATA_W and DEPTH; ports wr_en, wr_data, rd_en, rd_data, full, empty, level).
REQ-032 uart_tx_fifo SHALL contain the FSM, the tx_data register and the overflow logic, and instantiate sync_fifo once.

Verification
REQ-033 Reset, then write 0x73 while idle -> tx_start pulse 2 cycles after the write edge with tx_data=0x73; level returns to 0.
REQ-034 Burst-write "silicon craft" (13 chars) with tx_busy held high by a model for 10 cycles per char -> 13 launches, in order, each only after tx_busy falls.
REQ-035 Write 17 chars back-to-back with tx_busy=1 throughout, DEPTH=16 -> the first char is popped into tx_data; later writes eventually drop; level never exceeds 16, full=1 while 16 are held, overflow pulses once per dropped write.
REQ-036 Transmitter model never raises tx_busy -> FSM returns to IDLE 4 cycles after WAIT_BUSY entry; the next char launches.
REQ-037 Assert rst_n=0 during WAIT_DONE with 5 chars queued -> all outputs return to reset values asynchronously; no launch after release until a new write.
REQ-038 Simultaneous write and pop with level=3 -> level stays 3; data order preserved across pointer wrap after 40 chars.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: launch FSM encoding and timing constants.
package uart_pkg;

    // Default character width in bits.
    localparam int unsigned DefaultDataW = 8;

    // Cycles WAIT_BUSY tolerates with tx_busy low before giving up on the handshake.
    localparam int unsigned BusyTimeout = 4;
    localparam int unsigned BusyCntW    = $clog2(BusyTimeout);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo import uart_pkg::*; #(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              wr_accept;
    logic              rd_accept;

    // Same index with differing wrap bits means the write pointer has lapped the read pointer.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign level     = wr_ptr_q - rd_ptr_q;
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;
    assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted writes and reads.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side character FIFO feeding a UART transmitter through a launch/handshake FSM.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy
);

    tx_state_e             state_q, state_d;
    logic [BusyCntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  overflow_q, overflow_d;
    logic                  avail_q, avail_d;
    logic                  pop;
    logic [DATA_W-1:0]     fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == StLaunch);

    // Launch FSM: pop a character, pulse tx_start, then wait for the transmitter handshake.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                // avail_q lags the FIFO by one cycle; it can only be stale in LAUNCH, never here.
                if (avail_q && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (wait_cnt_q == BusyCntW'(BusyTimeout - 1)) begin
                    // Transmitter finished or ignored the launch; the character is not retried.
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + BusyCntW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next state: capture popped head, flag dropped writes, delay the non-empty view.
    always_comb begin
        tx_data_d  = pop ? fifo_rd_data : tx_data_q;
        overflow_d = wr_en && fifo_full;
        avail_d    = !fifo_empty;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            avail_q    <= avail_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, timing sequences and a queue-based model.
module tb_uart_tx_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    typedef struct {
        logic              wr;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic [LW-1:0]     level;
        logic              full;
        logic              ovf;
        logic              start;
        logic [DATA_W-1:0] txd;
    } vec_t;

    vec_t vecs [20];

    // Reference model state: accepted-but-unlaunched characters in write order.
    logic [DATA_W-1:0] exp_q [$];
    int   mcnt;
    int   launches;
    int   accepted;
    int   busy_left;
    int   busy_len;
    bit   rand_busy;
    logic prev_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_level"},    32'(level),    0);
        chk({tag, "_empty"},    32'(empty),    1);
        chk({tag, "_full"},     32'(full),     0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_tx_start"}, 32'(tx_start), 0);
        chk({tag, "_tx_data"},  32'(tx_data),  0);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mcnt       = 0;
        launches   = 0;
        accepted   = 0;
        busy_left  = 0;
        prev_start = 1'b0;
    endtask

    // One clock with the currently driven write; model the FIFO count/order and a transmitter.
    task automatic step();
        logic              w;
        logic              b;
        logic [DATA_W-1:0] d;
        logic              acc;
        logic              pop;
        w = wr_en;
        b = tx_busy;
        d = wr_data;
        @(negedge clk);
        pop = tx_start;
        acc = w && (mcnt < int'(DEPTH));
        chk("model_overflow", 32'(overflow), 32'(w && (mcnt == int'(DEPTH))));
        if (pop) begin
            chk("launch_needs_data", 32'(mcnt > 0), 1);
            chk("launch_busy_low", 32'(b), 0);
            chk("no_back_to_back", 32'(prev_start), 0);
            if (exp_q.size() > 0) begin
                chk("launch_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            launches++;
            if (mcnt > 0) begin
                mcnt--;
            end
        end
        if (acc) begin
            exp_q.push_back(d);
            mcnt++;
            accepted++;
        end
        chk("model_level", 32'(level), 32'(mcnt));
        chk("model_full", 32'(full), 32'(mcnt == int'(DEPTH)));
        chk("model_empty", 32'(empty), 32'(mcnt == 0));
        prev_start = pop;
        if (pop) begin
            busy_left = rand_busy ? int'($urandom_range(0, 8)) : busy_len;
        end
        tx_busy = (busy_left > 0);
        if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;

        // Fill past capacity with the transmitter stuck busy after the first launch.
        for (int k = 0; k < 20; k++) begin
            int lv;
            lv = (k == 0) ? 1 : ((k == 1) ? 2 : ((k > int'(DEPTH)) ? int'(DEPTH) : k));
            vecs[k].wr    = (k < 19);
            vecs[k].data  = 8'(8'h30 + k);
            vecs[k].busy  = (k >= 3);
            vecs[k].level = LW'(lv);
            vecs[k].full  = (lv == int'(DEPTH));
            vecs[k].ovf   = (k == 17) || (k == 18);
            vecs[k].start = (k == 2);
            vecs[k].txd   = (k >= 2) ? 8'h30 : 8'h00;
        end

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            wr_en   = vecs[k].wr;
            wr_data = vecs[k].data;
            tx_busy = vecs[k].busy;
            @(negedge clk);
            chk($sformatf("vec%0d_level", k),    32'(level),    32'(vecs[k].level));
            chk($sformatf("vec%0d_full", k),     32'(full),     32'(vecs[k].full));
            chk($sformatf("vec%0d_empty", k),    32'(empty),    0);
            chk($sformatf("vec%0d_overflow", k), 32'(overflow), 32'(vecs[k].ovf));
            chk($sformatf("vec%0d_tx_start", k), 32'(tx_start), 32'(vecs[k].start));
            chk($sformatf("vec%0d_tx_data", k),  32'(tx_data),  32'(vecs[k].txd));
        end

        // Asynchronous reset while waiting on a busy transmitter with characters queued.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        wr_en   = 1'b0;
        tx_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_no_launch", 32'(tx_start), 0);
            chk("post_reset_level", 32'(level), 0);
        end

        // Write-to-launch latency, then a launch the transmitter ignores (timeout path).
        wr_en   = 1'b1;
        wr_data = 8'h73;
        @(negedge clk);
        wr_en = 1'b0;
        chk("lat_n_level", 32'(level), 1);
        chk("lat_n_start", 32'(tx_start), 0);
        @(negedge clk);
        chk("lat_n1_start", 32'(tx_start), 0);
        @(negedge clk);
        chk("lat_n2_start", 32'(tx_start), 1);
        chk("lat_n2_data", 32'(tx_data), 32'h73);
        chk("lat_n2_level", 32'(level), 0);
        wr_en   = 1'b1;
        wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        chk("to_n3_start", 32'(tx_start), 0);
        chk("to_n3_level", 32'(level), 1);
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("to_n%0d_start", i), 32'(tx_start), 0);
        end
        @(negedge clk);
        chk("to_n8_start", 32'(tx_start), 1);
        chk("to_n8_data", 32'(tx_data), 32'h41);
        chk("to_n8_level", 32'(level), 0);
        @(negedge clk);
        chk("to_n9_start", 32'(tx_start), 0);

        // Burst of a text string against a transmitter busy for 10 cycles per character.
        apply_reset();
        model_reset();
        rand_busy = 1'b0;
        busy_len  = 10;
        s = "silicon craft";
        for (int i = 0; i < s.len(); i++) begin
            wr_en   = 1'b1;
            wr_data = s[i];
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 400 && launches < 13; i++) begin
            step();
        end
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("craft_launches", 32'(launches), 13);
        chk("craft_drained", 32'(exp_q.size()), 0);

        // Random writes and random transmitter behaviour, including ignored launches.
        apply_reset();
        model_reset();
        rand_busy = 1'b1;
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 600 && exp_q.size() > 0; i++) begin
            step();
        end
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("random_drained", 32'(exp_q.size()), 0);
        chk("random_all_launched", 32'(launches), 32'(accepted));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
